// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the multiplier/divider op-type codes used by the arithmetic unit.
package seq_restoring_divider_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } div_state_e;

   localparam logic [1:0] OP_MUL  = 2'd0;
   localparam logic [1:0] OP_DIV  = 2'd1;
   localparam logic [1:0] OP_CHK  = 2'd2;

endpackage

// File: rtl/seq_restoring_divider_div_step_cell.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep or restore the result.
module div_step_cell #(
   parameter int N = 8
) (
   input  logic [N:0]   r,
   input  logic         q_msb,
   input  logic [N-1:0] divisor,
   output logic [N:0]   r_next,
   output logic         q_bit
);

   logic [N:0] r_shift;
   logic [N:0] trial;

   // R stays below the divisor, so its top bit is always zero and drops out here.
   assign r_shift = (N+1)'({r, q_msb});
   assign trial   = r_shift - {1'b0, divisor};
   assign q_bit   = ~trial[N];
   assign r_next  = trial[N] ? r_shift : trial;

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on the operand and result sides.
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N+1);

   div_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  q_q, q_d;
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N:0]    r_q, r_d;
   logic          dbz_q, dbz_d;

   logic [N:0]    r_step;
   logic          q_bit;

   div_step_cell #(.N(N)) u_step (
      .r       (r_q),
      .q_msb   (q_q[N-1]),
      .divisor (dvs_q),
      .r_next  (r_step),
      .q_bit   (q_bit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               dvs_d = divisor;
               if (divisor == '0) begin
                  state_d = S_DONE;
                  q_d     = '1;
                  r_d     = {1'b0, dividend};
                  dbz_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = S_BUSY;
                  q_d     = dividend;
                  r_d     = '0;
                  dbz_d   = 1'b0;
                  cnt_d   = CW'(N);
               end
            end
         end
         S_BUSY: begin
            // Q shifts left as its msb feeds the step cell; the new quotient bit enters at the bottom.
            r_d   = r_step;
            q_d   = (q_q << 1) | N'(q_bit);
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign quotient    = q_q;
   assign remainder   = r_q[N-1:0];
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus a random
// sweep compared against plain integer division.
module tb_seq_restoring_divider;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   int errors = 0;
   int checks = 0;

   seq_restoring_divider #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation, measure latency from the accept edge, check the result,
   // optionally stall the consumer (poking in_valid meanwhile), then retire it.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input int hold, input bit poke);
      logic [N-1:0] eq, er;
      logic         ed;
      int           exp_lat, edges;
      if (b == 0) begin
         eq = '1; er = a; ed = 1'b1; exp_lat = 0;
      end else begin
         eq = N'(a / b); er = N'(a % b); ed = 1'b0; exp_lat = N;
      end
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      dividend = '0;
      divisor  = '0;
      edges = 0;
      while (!out_valid && edges < 40) begin
         tick();
         edges++;
      end
      check("latency", 32'(edges), 32'(exp_lat));
      check("quotient", 32'(quotient), 32'(eq));
      check("remainder", 32'(remainder), 32'(er));
      check("div_by_zero", 32'(div_by_zero), 32'(ed));
      check("in_ready_done", 32'(in_ready), 32'd0);
      if (b != 0) begin
         check("identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
         check("rem_lt_divisor", 32'(remainder < b), 32'd1);
      end
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            in_valid = 1'b1;
            dividend = ~a;
            divisor  = 8'd2;
         end
         tick();
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_quotient", 32'(quotient), 32'(eq));
         check("hold_remainder", 32'(remainder), 32'(er));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid_after_handshake", 32'(out_valid), 32'd0);
      check("in_ready_after_handshake", 32'(in_ready), 32'd1);
   endtask

   initial begin
      bit saw_valid;
      logic [N-1:0] ra, rb;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_quotient", 32'(quotient), 32'd0);
      check("reset_remainder", 32'(remainder), 32'd0);
      check("reset_dbz", 32'(div_by_zero), 32'd0);

      // out_ready while idle must not disturb anything
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_out_ready_ignored", 32'(out_valid), 32'd0);

      run_op(8'd200, 8'd7, 0, 1'b0);
      run_op(8'd13, 8'd0, 1, 1'b0);
      run_op(8'd5, 8'd9, 0, 1'b0);
      run_op(8'd255, 8'd1, 0, 1'b0);
      run_op(8'd255, 8'd255, 0, 1'b0);
      run_op(8'd0, 8'd0, 0, 1'b0);
      run_op(8'd0, 8'd37, 0, 1'b0);
      run_op(8'd100, 8'd3, 10, 1'b1);

      // reset in the middle of 200/7, during the fourth iteration edge
      dividend = 8'd200;
      divisor  = 8'd7;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_quotient", 32'(quotient), 32'd0);
      check("midrst_remainder", 32'(remainder), 32'd0);
      check("midrst_dbz", 32'(div_by_zero), 32'd0);
      saw_valid = 1'b0;
      repeat (12) begin
         tick();
         if (out_valid) saw_valid = 1'b1;
      end
      check("midrst_no_output", 32'(saw_valid), 32'd0);
      run_op(8'd50, 8'd5, 0, 1'b0);

      for (int k = 0; k < 2000; k++) begin
         ra = N'($urandom_range(0, 255));
         rb = N'($urandom_range(1, 255));
         run_op(ra, rb, int'($urandom_range(0, 2)), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
